// File: rtl/udcnt_pkg.sv
// Shared types for the up/down counter: the per-edge operation and its priority decode.
package udcnt_pkg;

  typedef enum logic [1:0] {
    OP_HOLD = 2'd0,
    OP_LOAD = 2'd1,
    OP_UP   = 2'd2,
    OP_DOWN = 2'd3
  } op_t;

  // Load ignores en; up and down together cancel to a hold.
  function automatic op_t decodeOp(input logic load, input logic en,
                                   input logic up, input logic down);
    if (load)
      return OP_LOAD;
    else if (en && up && !down)
      return OP_UP;
    else if (en && down && !up)
      return OP_DOWN;
    else
      return OP_HOLD;
  endfunction

endpackage

// File: rtl/udcnt_next.sv
// Combinational next-value unit: computes the next count and the overflow/underflow flags for one op.
module udcnt_next
  import udcnt_pkg::*;
#(
  parameter int WIDTH  = 8,
  parameter int STEP_W = 4
) (
  input  logic [WIDTH-1:0]  count,
  input  logic [WIDTH-1:0]  limit,
  input  logic [WIDTH-1:0]  load_val,
  input  logic [STEP_W-1:0] step,
  input  logic              sat,
  input  op_t               op,
  output logic [WIDTH-1:0]  next_count,
  output logic              ovf_n,
  output logic              unf_n
);

  logic [WIDTH:0]   sum;
  logic [WIDTH-1:0] stepExt;

  assign stepExt = WIDTH'(step);
  assign sum     = (WIDTH+1)'(count) + (WIDTH+1)'(step);

  // A count above a lowered limit overflows on the next up even with step=0,
  // while a down still subtracts normally without clamping.
  always_comb begin
    next_count = count;
    ovf_n      = 1'b0;
    unf_n      = 1'b0;
    unique case (op)
      OP_LOAD: begin
        next_count = (load_val > limit) ? limit : load_val;
      end
      OP_UP: begin
        if (sum <= {1'b0, limit}) begin
          next_count = sum[WIDTH-1:0];
        end else begin
          next_count = sat ? limit : '0;
          ovf_n      = 1'b1;
        end
      end
      OP_DOWN: begin
        if (stepExt <= count) begin
          next_count = count - stepExt;
        end else begin
          next_count = sat ? '0 : limit;
          unf_n      = 1'b1;
        end
      end
      default: begin
        next_count = count;
      end
    endcase
  end

endmodule

// File: rtl/updown_counter_p.sv
// Parametrised up/down counter with programmable limit, step, load and wrap/saturate.
// Optional compare-match pulse is enabled by defining UDCNT_MATCH_EN.
module updown_counter_p
  import udcnt_pkg::*;
#(
  parameter int WIDTH  = 8,
  parameter int STEP_W = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              en,
  input  logic              up,
  input  logic              down,
  input  logic              load,
  input  logic [WIDTH-1:0]  load_val,
  input  logic [WIDTH-1:0]  limit,
  input  logic [STEP_W-1:0] step,
  input  logic              sat,
`ifdef UDCNT_MATCH_EN
  input  logic [WIDTH-1:0]  cmp_val,
  output logic              match,
`endif
  output logic [WIDTH-1:0]  count,
  output logic              ovf,
  output logic              unf,
  output logic              at_max,
  output logic              at_zero
);

  op_t              op;
  logic [WIDTH-1:0] nextCount;
  logic             ovfNext;
  logic             unfNext;

  assign op = decodeOp(load, en, up, down);

  udcnt_next #(
    .WIDTH  (WIDTH),
    .STEP_W (STEP_W)
  ) u_next (
    .count      (count),
    .limit      (limit),
    .load_val   (load_val),
    .step       (step),
    .sat        (sat),
    .op         (op),
    .next_count (nextCount),
    .ovf_n      (ovfNext),
    .unf_n      (unfNext)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      count <= '0;
      ovf   <= 1'b0;
      unf   <= 1'b0;
    end else begin
      count <= nextCount;
      ovf   <= ovfNext;
      unf   <= unfNext;
    end
  end

`ifdef UDCNT_MATCH_EN
  // Pulse only when the count actually moves onto cmp_val, so holding there stays quiet.
  always_ff @(posedge clk) begin
    if (reset)
      match <= 1'b0;
    else
      match <= (nextCount != count) && (nextCount == cmp_val);
  end
`endif

  assign at_max  = (count >= limit);
  assign at_zero = (count == '0);

endmodule

// File: tb/tb_updown_counter_p.sv
// Directed self-checking bench for updown_counter_p (WIDTH=8, STEP_W=4).
module tb_updown_counter_p;

  localparam int WIDTH  = 8;
  localparam int STEP_W = 4;

  logic              clk = 1'b0;
  logic              reset;
  logic              en;
  logic              up;
  logic              down;
  logic              load;
  logic [WIDTH-1:0]  load_val;
  logic [WIDTH-1:0]  limit;
  logic [STEP_W-1:0] step;
  logic              sat;
  logic [WIDTH-1:0]  count;
  logic              ovf;
  logic              unf;
  logic              at_max;
  logic              at_zero;
`ifdef UDCNT_MATCH_EN
  logic [WIDTH-1:0]  cmp_val;
  logic              match;
`endif

  int vectors     = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  updown_counter_p #(
    .WIDTH  (WIDTH),
    .STEP_W (STEP_W)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .en       (en),
    .up       (up),
    .down     (down),
    .load     (load),
    .load_val (load_val),
    .limit    (limit),
    .step     (step),
    .sat      (sat),
`ifdef UDCNT_MATCH_EN
    .cmp_val  (cmp_val),
    .match    (match),
`endif
    .count    (count),
    .ovf      (ovf),
    .unf      (unf),
    .at_max   (at_max),
    .at_zero  (at_zero)
  );

  // Advance one edge and settle, so outputs are sampled away from the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic setIdle();
    reset = 1'b0; en = 1'b0; up = 1'b0; down = 1'b0; load = 1'b0;
  endtask

  task automatic doLoad(input logic [WIDTH-1:0] v);
    setIdle();
    load = 1'b1; load_val = v;
    tick();
    load = 1'b0;
  endtask

  task automatic test_reset();
    setIdle();
    reset = 1'b1; load_val = '0; limit = 8'd9; step = 4'd1; sat = 1'b0;
`ifdef UDCNT_MATCH_EN
    cmp_val = 8'hFF;
`endif
    tick(); tick();
    reset = 1'b0;
    vectors++;
    if (count !== 8'd0 || ovf !== 1'b0 || unf !== 1'b0 || at_zero !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL reset: count=%0d ovf=%b unf=%b at_zero=%b, want 0/0/0/1",
               count, ovf, unf, at_zero);
    end
  endtask

  task automatic test_wrap();
    logic [WIDTH-1:0] expCount;
    setIdle();
    limit = 8'd9; step = 4'd1; sat = 1'b0; en = 1'b1; up = 1'b1;
    for (int i = 1; i <= 10; i++) begin
      tick();
      expCount = (i == 10) ? 8'd0 : WIDTH'(i);
      vectors++;
      if (count !== expCount || ovf !== (i == 10) || unf !== 1'b0) begin
        miscompares++;
        $display("[TB] FAIL wrap[%0d]: count=%0d ovf=%b unf=%b, want %0d/%b/0",
                 i, count, ovf, unf, expCount, (i == 10));
      end
      vectors++;
      if (at_max !== (i == 9)) begin
        miscompares++;
        $display("[TB] FAIL wrap_at_max[%0d]: at_max=%b, want %b", i, at_max, (i == 9));
      end
    end
    setIdle();
    tick();
    vectors++;
    if (count !== 8'd0 || ovf !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL wrap_hold: count=%0d ovf=%b, want 0/0", count, ovf);
    end
  endtask

  task automatic test_saturate();
    limit = 8'd100; sat = 1'b1; step = 4'd7;
    doLoad(8'd98);
    en = 1'b1; up = 1'b1;
    for (int i = 0; i < 2; i++) begin
      tick();
      vectors++;
      if (count !== 8'd100 || ovf !== 1'b1 || unf !== 1'b0 || at_max !== 1'b1) begin
        miscompares++;
        $display("[TB] FAIL sat_up[%0d]: count=%0d ovf=%b unf=%b at_max=%b, want 100/1/0/1",
                 i, count, ovf, unf, at_max);
      end
    end
    setIdle();
    tick();
    vectors++;
    if (count !== 8'd100 || ovf !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL sat_idle: count=%0d ovf=%b, want 100/0", count, ovf);
    end
  endtask

  task automatic test_underflow();
    limit = 8'd20; step = 4'd5; sat = 1'b0;
    doLoad(8'd3);
    en = 1'b1; down = 1'b1;
    tick();
    vectors++;
    if (count !== 8'd20 || unf !== 1'b1 || ovf !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL unf_wrap: count=%0d unf=%b ovf=%b, want 20/1/0", count, unf, ovf);
    end
    sat = 1'b1;
    doLoad(8'd3);
    vectors++;
    if (unf !== 1'b0 || count !== 8'd3) begin
      miscompares++;
      $display("[TB] FAIL unf_load: count=%0d unf=%b, want 3/0", count, unf);
    end
    en = 1'b1; down = 1'b1;
    tick();
    vectors++;
    if (count !== 8'd0 || unf !== 1'b1 || at_zero !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL unf_sat: count=%0d unf=%b at_zero=%b, want 0/1/1", count, unf, at_zero);
    end
  endtask

  task automatic test_load_priority();
    setIdle();
    limit = 8'd50; sat = 1'b0; step = 4'd1;
    load = 1'b1; load_val = 8'd200; en = 1'b1; up = 1'b1;
    tick();
    vectors++;
    if (count !== 8'd50 || ovf !== 1'b0 || unf !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL load_clamp: count=%0d ovf=%b unf=%b, want 50/0/0", count, ovf, unf);
    end
    load = 1'b0; up = 1'b1; down = 1'b1;
    tick();
    vectors++;
    if (count !== 8'd50 || ovf !== 1'b0 || unf !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL up_and_down_hold: count=%0d ovf=%b unf=%b, want 50/0/0", count, ovf, unf);
    end
  endtask

  task automatic test_limit_lowered();
    limit = 8'd50; sat = 1'b0; step = 4'd5;
    doLoad(8'd30);
    limit = 8'd10;
    tick();
    vectors++;
    if (count !== 8'd30 || at_max !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL lowered_hold: count=%0d at_max=%b, want 30/1", count, at_max);
    end
    en = 1'b1; down = 1'b1;
    tick();
    vectors++;
    if (count !== 8'd25 || unf !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL lowered_down: count=%0d unf=%b, want 25/0", count, unf);
    end
    down = 1'b0; up = 1'b1; step = 4'd0;
    tick();
    vectors++;
    if (count !== 8'd0 || ovf !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL lowered_up_step0: count=%0d ovf=%b, want 0/1", count, ovf);
    end
  endtask

  task automatic test_step_zero();
    limit = 8'd20; sat = 1'b0; step = 4'd0;
    doLoad(8'd5);
    en = 1'b1; up = 1'b1;
    tick();
    vectors++;
    if (count !== 8'd5 || ovf !== 1'b0 || unf !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL step0_up: count=%0d ovf=%b unf=%b, want 5/0/0", count, ovf, unf);
    end
    up = 1'b0; down = 1'b1;
    tick();
    vectors++;
    if (count !== 8'd5 || ovf !== 1'b0 || unf !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL step0_down: count=%0d ovf=%b unf=%b, want 5/0/0", count, ovf, unf);
    end
  endtask

  task automatic test_back_to_back();
    limit = 8'd5; sat = 1'b0; step = 4'd3;
    doLoad(8'd4);
    en = 1'b1; up = 1'b1;
    tick();
    vectors++;
    if (count !== 8'd0 || ovf !== 1'b1 || unf !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL b2b_up: count=%0d ovf=%b unf=%b, want 0/1/0", count, ovf, unf);
    end
    up = 1'b0; down = 1'b1;
    tick();
    vectors++;
    if (count !== 8'd5 || ovf !== 1'b0 || unf !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL b2b_down: count=%0d ovf=%b unf=%b, want 5/0/1", count, ovf, unf);
    end
    down = 1'b0; up = 1'b1; step = 4'd0;
    tick();
    vectors++;
    if (count !== 8'd5 || ovf !== 1'b0 || unf !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL b2b_clear: count=%0d ovf=%b unf=%b, want 5/0/0", count, ovf, unf);
    end
  endtask

  task automatic test_reset_mid();
    limit = 8'd100; sat = 1'b0; step = 4'd1;
    doLoad(8'd100);
    en = 1'b1; up = 1'b1; reset = 1'b1;
    tick();
    reset = 1'b0;
    setIdle();
    vectors++;
    if (count !== 8'd0 || ovf !== 1'b0 || unf !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL reset_mid: count=%0d ovf=%b unf=%b, want 0/0/0", count, ovf, unf);
    end
  endtask

`ifdef UDCNT_MATCH_EN
  task automatic test_match();
    logic expMatch;
    setIdle();
    reset = 1'b1; limit = 8'd100; step = 4'd2; sat = 1'b0; cmp_val = 8'd4;
    tick();
    reset = 1'b0;
    vectors++;
    if (match !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL match_reset: match=%b, want 0", match);
    end
    en = 1'b1; up = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      if (i == 3) en = 1'b0;
      tick();
      expMatch = (i == 2);
      vectors++;
      if (match !== expMatch) begin
        miscompares++;
        $display("[TB] FAIL match[%0d]: match=%b count=%0d, want %b", i, match, count, expMatch);
      end
    end
    setIdle();
  endtask
`endif

  initial begin
    test_reset();
    test_wrap();
    test_saturate();
    test_underflow();
    test_load_priority();
    test_limit_lowered();
    test_step_zero();
    test_back_to_back();
    test_reset_mid();
`ifdef UDCNT_MATCH_EN
    test_match();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
